ita_activation_pipe: RTL and testbench

//  Multi-lane, pipelined activation + requantisation unit for the ITA feed-forward path.

---
 rtl/ita_activation_pipe_pkg.sv | 45 ++++
 rtl/ita_activation_pipe_lane.sv | 131 +++++++++++++
 rtl/ita_activation_pipe.sv | 108 ++++++++++
 tb/tb_ita_activation_pipe.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ita_activation_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Package : ita_package
// Brief   : Shared types and widths for the ITA activation/requant pipeline.
// Rev     : 1.0 - initial release
// ============================================================================
package ita_package;

    localparam int REQUANT_WIDTH        = 8;
    localparam int GELU_CONSTANTS_WIDTH = 16;
    localparam int GELU_PRE_RQS_WIDTH   = 32;
    localparam int EMS                  = 8;

    typedef logic signed [REQUANT_WIDTH-1:0] requant_t;

    typedef enum logic [1:0] {
        ACT_IDENT = 2'b00,
        ACT_RELU  = 2'b01,
        ACT_GELU  = 2'b10
    } act_mode_e;

    // Requant fields are consumed in the last stage; they ride along with the beat.
    typedef struct packed {
        logic signed [EMS-1:0] eps_mult;
        logic        [EMS-1:0] shift;
        logic signed [EMS-1:0] add;
    } act_rqs_t;

    typedef struct packed {
        act_mode_e                               mode;
        logic signed [GELU_CONSTANTS_WIDTH-1:0]  one;
        act_rqs_t                                rqs;
    } act_cfg_t;

    // The unused encoding 2'b11 behaves as identity.
    function automatic act_mode_e decode_mode(input logic [1:0] m);
        case (m)
            2'b01:   return ACT_RELU;
            2'b10:   return ACT_GELU;
            default: return ACT_IDENT;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/ita_activation_pipe_lane.sv
`default_nettype none
// ============================================================================
// Module : ita_act_lane
// Brief  : Single-lane S1/S2/S3 datapath: activation (ident/ReLU/I-GELU) then requant.
// Rev    : 1.0 - initial release
// ============================================================================
module ita_act_lane
    import ita_package::*;
#(
    parameter int WI  = 8,
    parameter int CW  = 16,
    parameter int PW  = 32,
    parameter int EMS = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_load1,
    input  logic                  i_load2,
    input  logic                  i_load3,
    input  logic signed [WI-1:0]  i_x,
    input  act_mode_e             i_mode0,
    input  logic signed [CW-1:0]  i_b,
    input  logic signed [CW-1:0]  i_c,
    input  act_mode_e             i_mode1,
    input  logic signed [CW-1:0]  i_one1,
    input  logic signed [EMS-1:0] i_eps2,
    input  logic        [EMS-1:0] i_shift2,
    input  logic signed [EMS-1:0] i_add2,
    output logic signed [WI-1:0]  o_data,
    output logic                  o_sat
);

    localparam int RW = PW + EMS;
    localparam logic signed [WI-1:0]  c_x_lo      = {1'b1, {(WI-1){1'b0}}};
    localparam logic signed [WI-1:0]  c_x_gelu_lo = {1'b1, {(WI-2){1'b0}}, 1'b1};
    localparam logic signed [WI-1:0]  c_omax      = {1'b0, {(WI-1){1'b1}}};
    localparam logic signed [WI-1:0]  c_omin      = {1'b1, {(WI-1){1'b0}}};
    localparam logic        [EMS-1:0] c_shift_lim = EMS'(RW);
    localparam logic        [RW-1:0]  c_one_bit   = {{(RW-1){1'b0}}, 1'b1};

    logic signed [WI-1:0] w_xc;
    logic signed [WI-1:0] w_abs;
    logic signed [PW-1:0] w_negb;
    logic signed [PW-1:0] w_a;
    logic signed [PW-1:0] w_d;
    logic signed [PW-1:0] w_l;
    logic signed [PW-1:0] w_s1;

    logic signed [WI-1:0] r_x;
    logic                 r_neg;
    logic signed [PW-1:0] r_s1;

    always_comb begin
        w_xc   = (i_x == c_x_lo) ? c_x_gelu_lo : i_x;
        w_abs  = w_xc[WI-1] ? -w_xc : w_xc;
        w_negb = -PW'(i_b);
        w_a    = (PW'(w_abs) < w_negb) ? PW'(w_abs) : w_negb;
        w_d    = w_a + PW'(i_b);
        w_l    = w_d * w_d + PW'(i_c);
        case (i_mode0)
            ACT_GELU: w_s1 = w_l;
            ACT_RELU: w_s1 = i_x[WI-1] ? '0 : PW'(i_x);
            default:  w_s1 = PW'(i_x);
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x   <= '0;
            r_neg <= 1'b0;
            r_s1  <= '0;
        end else if (i_load1) begin
            r_x   <= i_x;
            r_neg <= i_x[WI-1];
            r_s1  <= w_s1;
        end
    end

    // For GELU, r_s1 carries the polynomial L; otherwise it already holds the result.
    logic signed [PW-1:0] w_t;
    logic signed [PW-1:0] w_s2;
    logic signed [PW-1:0] r_s2;

    always_comb begin
        w_t  = (r_neg ? -r_s1 : r_s1) + PW'(i_one1);
        w_s2 = (i_mode1 == ACT_GELU) ? PW'(r_x) * w_t : r_s1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2 <= '0;
        end else if (i_load2) begin
            r_s2 <= w_s2;
        end
    end

    logic signed [RW-1:0] w_p;
    logic signed [RW-1:0] w_s;
    logic        [RW-1:0] w_mask;
    logic                 w_rnd;
    logic signed [RW:0]   w_v;

    always_comb begin
        w_p    = RW'(r_s2) * RW'(i_eps2);
        w_s    = w_p >>> i_shift2;
        // shift==0 wraps shift-1 far out of range, so the mask is empty there.
        w_mask = c_one_bit << (i_shift2 - 1'b1);
        w_rnd  = (i_shift2 < c_shift_lim) && (|(w_p & w_mask));
        w_v    = (RW+1)'(w_s) + (RW+1)'(w_rnd) + (RW+1)'(i_add2);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_data <= '0;
            o_sat  <= 1'b0;
        end else if (i_load3) begin
            if (w_v > (RW+1)'(c_omax)) begin
                o_data <= c_omax;
                o_sat  <= 1'b1;
            end else if (w_v < (RW+1)'(c_omin)) begin
                o_data <= c_omin;
                o_sat  <= 1'b1;
            end else begin
                o_data <= w_v[WI-1:0];
                o_sat  <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ita_activation_pipe.sv
`default_nettype none
// ============================================================================
// Module : ita_activation_pipe
// Brief  : N-lane 3-stage activation + requant pipe with valid/ready on both sides.
// Rev    : 1.0 - initial release
// ============================================================================
module ita_activation_pipe
    import ita_package::*;
#(
    parameter int N_LANES = 16,
    parameter int WI      = 8,
    parameter int CW      = 16,
    parameter int PW      = 32,
    parameter int EMS     = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    valid_i,
    output logic                    ready_o,
    input  logic [N_LANES*WI-1:0]   data_i,
    input  logic [1:0]              mode_i,
    input  logic signed [CW-1:0]    one_i,
    input  logic signed [CW-1:0]    b_i,
    input  logic signed [CW-1:0]    c_i,
    input  logic signed [EMS-1:0]   eps_mult_i,
    input  logic        [EMS-1:0]   shift_i,
    input  logic signed [EMS-1:0]   add_i,
    output logic                    valid_o,
    input  logic                    ready_i,
    output logic [N_LANES*WI-1:0]   data_o,
    output logic [N_LANES-1:0]      sat_o,
    output logic                    busy_o
);

    logic     r_v1, r_v2, r_v3;
    logic     w_en1, w_en2, w_en3;
    logic     w_load1, w_load2, w_load3;
    act_cfg_t w_cfg0;
    act_cfg_t r_cfg1;
    act_rqs_t r_rqs2;

    // A stage may take a new beat when empty or when its current beat moves on.
    assign w_en3   = ~r_v3 | ready_i;
    assign w_en2   = ~r_v2 | w_en3;
    assign w_en1   = ~r_v1 | w_en2;
    assign w_load1 = w_en1 & valid_i;
    assign w_load2 = w_en2 & r_v1;
    assign w_load3 = w_en3 & r_v2;

    assign ready_o = w_en1;
    assign valid_o = r_v3;
    assign busy_o  = r_v1 | r_v2 | r_v3;

    always_comb begin
        w_cfg0              = '0;
        w_cfg0.mode         = decode_mode(mode_i);
        w_cfg0.one          = one_i;
        w_cfg0.rqs.eps_mult = eps_mult_i;
        w_cfg0.rqs.shift    = shift_i;
        w_cfg0.rqs.add      = add_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_v1   <= 1'b0;
            r_v2   <= 1'b0;
            r_v3   <= 1'b0;
            r_cfg1 <= '0;
            r_rqs2 <= '0;
        end else begin
            if (w_en1)   r_v1   <= valid_i;
            if (w_en2)   r_v2   <= r_v1;
            if (w_en3)   r_v3   <= r_v2;
            if (w_load1) r_cfg1 <= w_cfg0;
            if (w_load2) r_rqs2 <= r_cfg1.rqs;
        end
    end

    generate
        for (genvar g = 0; g < N_LANES; g++) begin : g_lane
            ita_act_lane #(
                .WI  (WI),
                .CW  (CW),
                .PW  (PW),
                .EMS (EMS)
            ) u_lane (
                .clk      (clk_i),
                .rst      (rst_i),
                .i_load1  (w_load1),
                .i_load2  (w_load2),
                .i_load3  (w_load3),
                .i_x      (data_i[g*WI +: WI]),
                .i_mode0  (w_cfg0.mode),
                .i_b      (b_i),
                .i_c      (c_i),
                .i_mode1  (r_cfg1.mode),
                .i_one1   (r_cfg1.one),
                .i_eps2   (r_rqs2.eps_mult),
                .i_shift2 (r_rqs2.shift),
                .i_add2   (r_rqs2.add),
                .o_data   (data_o[g*WI +: WI]),
                .o_sat    (sat_o[g])
            );
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_ita_activation_pipe.sv
`default_nettype none
// ============================================================================
// Module : tb_ita_activation_pipe
// Brief  : Self-checking bench: directed vector table, stream/stall, reset, random vs model.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_ita_activation_pipe;

    localparam int N  = 16;
    localparam int WI = 8;
    localparam int NW = N * WI;

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic            valid_i;
    logic            ready_o;
    logic [NW-1:0]   data_i;
    logic [1:0]      mode_i;
    logic [15:0]     one_i, b_i, c_i;
    logic [7:0]      eps_mult_i, shift_i, add_i;
    logic            valid_o;
    logic            ready_i;
    logic [NW-1:0]   data_o;
    logic [N-1:0]    sat_o;
    logic            busy_o;

    ita_activation_pipe #(.N_LANES(N), .WI(WI), .CW(16), .PW(32), .EMS(8)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .valid_i    (valid_i),
        .ready_o    (ready_o),
        .data_i     (data_i),
        .mode_i     (mode_i),
        .one_i      (one_i),
        .b_i        (b_i),
        .c_i        (c_i),
        .eps_mult_i (eps_mult_i),
        .shift_i    (shift_i),
        .add_i      (add_i),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .data_o     (data_o),
        .sat_o      (sat_o),
        .busy_o     (busy_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail   = 0;
    int n_retired = 0;

    task automatic check_int(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_vec(input string name, input logic [NW-1:0] act, input logic [NW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic longint wrap32(input longint v);
        logic signed [31:0] t;
        t = v[31:0];
        return longint'(t);
    endfunction

    // Reference: the activation and requant rules evaluated with wide integers.
    function automatic void model_lane(input int x, input int mode, input int one, input int b,
                                       input int c, input int eps, input int shift, input int add,
                                       output int y, output bit sat);
        longint pre, a, l, p, s, v;
        longint rnd;
        if (mode == 2) begin
            a = (x < 0) ? -longint'(x) : longint'(x);
            if (a > 127) a = 127;
            if (a > -longint'(b)) a = -longint'(b);
            l   = (a + b) * (a + b) + c;
            pre = wrap32(longint'(x) * (((x < 0) ? -l : l) + one));
        end else if (mode == 1) begin
            pre = (x < 0) ? 0 : x;
        end else begin
            pre = x;
        end
        p = pre * eps;
        if (shift >= 40) begin
            s   = (p < 0) ? -1 : 0;
            rnd = 0;
        end else begin
            s   = p >>> shift;
            rnd = (shift > 0 && (p - (s <<< shift)) >= (longint'(1) <<< (shift - 1))) ? 1 : 0;
        end
        v   = s + rnd + add;
        sat = (v > 127) || (v < -128);
        y   = (v > 127) ? 127 : (v < -128) ? -128 : int'(v);
    endfunction

    typedef struct {
        logic [NW-1:0] data;
        logic [N-1:0]  sat;
    } exp_t;
    exp_t exp_q[$];

    // Scoreboard: predict on every accepted input beat, compare on every retired output beat.
    initial begin
        bit            prev_stall = 0;
        logic [NW-1:0] prev_data  = '0;
        exp_t          e;
        int            y;
        bit            s;
        forever begin
            @(negedge clk_i);
            if (rst_i) begin
                prev_stall = 0;
            end else begin
                if (prev_stall) begin
                    check_int("hold_valid", longint'(valid_o), 1);
                    check_vec("hold_data", data_o, prev_data);
                end
                prev_stall = valid_o && !ready_i;
                prev_data  = data_o;
                if (valid_o && ready_i) begin
                    check_int("sb_nonempty", longint'(exp_q.size() != 0), 1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check_vec("sb_data", data_o, e.data);
                        check_int("sb_sat", longint'(sat_o), longint'(e.sat));
                        n_retired++;
                    end
                end
                if (valid_i && ready_o) begin
                    for (int k = 0; k < N; k++) begin
                        model_lane(int'($signed(data_i[k*WI +: WI])), int'(mode_i),
                                   int'($signed(one_i)), int'($signed(b_i)), int'($signed(c_i)),
                                   int'($signed(eps_mult_i)), int'(shift_i), int'($signed(add_i)), y, s);
                        e.data[k*WI +: WI] = WI'(y);
                        e.sat[k]           = s;
                    end
                    exp_q.push_back(e);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [1:0] mode;
        int x, one, b, c, eps, shift, add;
        int exp_y;
        bit exp_sat;
    } vec_t;

    task automatic drive(input logic [1:0] mode, input logic [NW-1:0] d, input int one, input int b,
                         input int c, input int eps, input int shift, input int add);
        mode_i     = mode;
        data_i     = d;
        one_i      = 16'(one);
        b_i        = 16'(b);
        c_i        = 16'(c);
        eps_mult_i = 8'(eps);
        shift_i    = 8'(shift);
        add_i      = 8'(add);
    endtask

    function automatic logic [NW-1:0] repl(input int v);
        logic [NW-1:0] r;
        for (int k = 0; k < N; k++) r[k*WI +: WI] = WI'(v);
        return r;
    endfunction

    task automatic run_vec(input vec_t v);
        int n;
        @(posedge clk_i); #1;
        drive(v.mode, repl(v.x), v.one, v.b, v.c, v.eps, v.shift, v.add);
        valid_i = 1'b1;
        @(negedge clk_i);
        check_int("vec_accept", longint'(ready_o), 1);
        @(posedge clk_i); #1;
        valid_i = 1'b0;
        n = 0;
        do begin
            @(negedge clk_i);
            n++;
        end while (!valid_o && n < 10);
        check_int("vec_latency", n, 3);
        check_vec("vec_data", data_o, repl(v.exp_y));
        check_int("vec_sat", longint'(sat_o), v.exp_sat ? longint'(16'hFFFF) : 0);
    endtask

    task automatic drain(input string name);
        int n = 0;
        @(posedge clk_i); #1;
        valid_i = 1'b0;
        ready_i = 1'b1;
        while ((exp_q.size() != 0 || valid_o) && n < 200) begin
            @(negedge clk_i);
            n++;
        end
        check_int(name, exp_q.size(), 0);
    endtask

    function automatic logic [NW-1:0] rand_lanes();
        logic [NW-1:0] r;
        for (int k = 0; k < N; k++) begin
            case ($urandom_range(0, 7))
                0:       r[k*WI +: WI] = 8'h80;
                1:       r[k*WI +: WI] = 8'h7F;
                2:       r[k*WI +: WI] = 8'h81;
                default: r[k*WI +: WI] = 8'($urandom);
            endcase
        end
        return r;
    endfunction

    vec_t          tbl[14];
    logic [NW-1:0] beats[10];

    initial begin
        int sent, t, base;
        int one, b, c, sh;
        logic [15:0] r16;

        //            mode   x    one  b   c  eps sh  add  exp  sat
        tbl[0]  = '{2'd0,   10,  0,   0,  0,  3,  1,  0,   15,  1'b0};
        tbl[1]  = '{2'd0,    5,  0,   0,  0,  1,  1,  0,    3,  1'b0};
        tbl[2]  = '{2'd0,   -5,  0,   0,  0,  1,  1,  0,   -2,  1'b0};
        tbl[3]  = '{2'd1,   -7,  0,   0,  0,  1,  0,  4,    4,  1'b0};
        tbl[4]  = '{2'd1,   20,  0,   0,  0,  1,  0,  4,   24,  1'b0};
        tbl[5]  = '{2'd1,  127,  0,   0,  0,  4,  0,  4,  127,  1'b1};
        tbl[6]  = '{2'd2,    2,  0,  -4,  0,  1,  0,  0,    8,  1'b0};
        tbl[7]  = '{2'd2,   -2,  0,  -4,  0,  1,  0,  0,    8,  1'b0};
        tbl[8]  = '{2'd2,   10,  0,  -4,  0,  1,  0,  0,    0,  1'b0};
        tbl[9]  = '{2'd2, -128,  0,  -4,  0,  1,  0,  0,    0,  1'b0};
        tbl[10] = '{2'd0,   -5,  0,   0,  0,  1, 40,  0,   -1,  1'b0};
        tbl[11] = '{2'd0,    5,  0,   0,  0,  1, 40,  0,    0,  1'b0};
        tbl[12] = '{2'd3,    9,  0,   0,  0,  1,  0,  0,    9,  1'b0};
        tbl[13] = '{2'd0, -128,  0,   0,  0,  2,  0,  0, -128,  1'b1};

        rst_i   = 1'b1;
        valid_i = 1'b0;
        ready_i = 1'b1;
        drive(2'd0, '0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clk_i);
        #1;
        check_int("rst_valid_o", longint'(valid_o), 0);
        check_int("rst_busy_o", longint'(busy_o), 0);
        check_vec("rst_data_o", data_o, '0);
        check_int("rst_sat_o", longint'(sat_o), 0);
        rst_i = 1'b0;
        @(negedge clk_i);
        check_int("rst_ready_o", longint'(ready_o), 1);

        // Directed vectors
        for (int i = 0; i < 14; i++) run_vec(tbl[i]);
        drain("directed_drain");

        // Stream of 10 beats with alternating modes and an output stall
        for (int i = 0; i < 10; i++) beats[i] = rand_lanes();
        base = n_retired;
        sent = 0;
        t    = 0;
        while ((sent < 10) && (t < 60)) begin
            @(posedge clk_i); #1;
            ready_i = !(t >= 2 && t <= 6);
            drive(2'(sent % 3), beats[sent], 3, -20, 7, 1, 2, 1);
            valid_i = 1'b1;
            @(negedge clk_i);
            if (t >= 3 && t <= 6) begin
                check_int("stall_ready_o", longint'(ready_o), 0);
                check_int("stall_busy_o", longint'(busy_o), 1);
            end
            if (t == 7) check_int("full_pipe_no_bubble", longint'(ready_o && valid_o), 1);
            if (ready_o) sent++;
            t++;
        end
        check_int("stream_sent", sent, 10);
        drain("stream_drain");
        check_int("stream_retired", n_retired - base, 10);

        // Reset with three beats in flight
        @(posedge clk_i); #1;
        ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(2'd0, rand_lanes(), 0, 0, 0, 1, 0, 0);
            valid_i = 1'b1;
            @(negedge clk_i);
            @(posedge clk_i); #1;
        end
        valid_i = 1'b0;
        check_int("inflight_busy", longint'(busy_o), 1);
        check_int("inflight_valid", longint'(valid_o), 1);
        #2;
        rst_i = 1'b1;
        #1;
        check_int("async_rst_valid_o", longint'(valid_o), 0);
        check_int("async_rst_busy_o", longint'(busy_o), 0);
        check_vec("async_rst_data_o", data_o, '0);
        exp_q.delete();
        repeat (2) @(posedge clk_i);
        #1;
        rst_i   = 1'b0;
        ready_i = 1'b1;
        @(negedge clk_i);
        check_int("post_rst_ready_o", longint'(ready_o), 1);
        check_int("post_rst_valid_o", longint'(valid_o), 0);
        run_vec(tbl[0]);
        drain("post_rst_drain");

        // Random traffic against the reference model
        for (int i = 0; i < 600; i++) begin
            @(posedge clk_i); #1;
            ready_i = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 4))
                0:       sh = 0;
                1:       sh = 1;
                2:       sh = 40;
                3:       sh = $urandom_range(0, 255);
                default: sh = $urandom_range(2, 20);
            endcase
            if ($urandom_range(0, 1) == 0) begin
                one = $urandom_range(0, 300) - 150;
                b   = -int'($urandom_range(0, 140));
                c   = $urandom_range(0, 400) - 200;
            end else begin
                r16 = 16'($urandom); one = int'($signed(r16));
                r16 = 16'($urandom); b   = int'($signed(r16));
                r16 = 16'($urandom); c   = int'($signed(r16));
            end
            drive(2'($urandom_range(0, 3)), rand_lanes(), one, b, c,
                  int'($signed(8'($urandom))), sh, int'($signed(8'($urandom))));
            valid_i = ($urandom_range(0, 4) != 0);
        end
        drain("random_drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
